// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: shares one AXI-Lite slave between a fetch reader (m0) and a load/store master (m1)
// clk/rst: clock and async active-high reset
// m0_ar*/m0_r*: requester 0 read channel; m1_ar*/m1_r*: requester 1 read channel
// m1_aw*/m1_w*/m1_b*: requester 1 write channel; s_*: shared slave, all five channels
module axi_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_rresp,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_rresp,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic                m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic                s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready
);
    typedef enum logic [1:0] {IDLE, RD0, RD1, WR} state_t;
    state_t state, state_nxt;
    logic last_grant, ar_done, aw_done, w_done;
    logic pick0, rd0, rd1, wr;
    // m0 wins unless requester 1 also asks and m0 was the last one granted
    assign pick0 = m0_arvalid && !((m1_arvalid || m1_awvalid) && !last_grant);
    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = pick0 ? RD0 : m1_awvalid ? WR : m1_arvalid ? RD1 : IDLE;
        else if (state == WR)
            state_nxt = (s_bvalid && s_bready) ? IDLE : WR;
        else
            state_nxt = (s_rvalid && s_rready) ? IDLE : state;
    end
    // done flags drop on the edge that returns to IDLE, so IDLE always starts clean
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            ar_done    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state   <= state_nxt;
            if (state == IDLE && state_nxt != IDLE)
                last_grant <= (state_nxt != RD0);
            ar_done <= (state_nxt != IDLE) && (ar_done || (s_arvalid && s_arready));
            aw_done <= (state_nxt != IDLE) && (aw_done || (s_awvalid && s_awready));
            w_done  <= (state_nxt != IDLE) && (w_done || (s_wvalid && s_wready));
        end
    end
    assign rd0 = (state == RD0);
    assign rd1 = (state == RD1);
    assign wr  = (state == WR);
    assign s_araddr   = rd1 ? m1_araddr : m0_araddr;
    assign s_arvalid  = ((rd0 && m0_arvalid) || (rd1 && m1_arvalid)) && !ar_done;
    assign m0_arready = rd0 && s_arready && !ar_done;
    assign m1_arready = rd1 && s_arready && !ar_done;
    assign s_rready   = (rd0 && m0_rready) || (rd1 && m1_rready);
    assign m0_rvalid  = rd0 && s_rvalid;
    assign m1_rvalid  = rd1 && s_rvalid;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;
    assign m0_rresp   = s_rresp;
    assign m1_rresp   = s_rresp;
    assign s_awaddr   = m1_awaddr;
    assign s_awvalid  = wr && m1_awvalid && !aw_done;
    assign m1_awready = wr && s_awready && !aw_done;
    assign s_wdata    = m1_wdata;
    assign s_wstrb    = m1_wstrb;
    assign s_wvalid   = wr && m1_wvalid && !w_done;
    assign m1_wready  = wr && s_wready && !w_done;
    assign s_bready   = wr && m1_bready;
    assign m1_bvalid  = wr && s_bvalid;
    assign m1_bresp   = s_bresp;
endmodule
